mem_rmw_unit: RTL and testbench
===============================

MEM_RMW_UNIT -- requirements
Module: mem_rmw_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits; the only legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Derived constant OFF_W = log2(DATA_W/8), the byte-offset width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  unit accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 dword; 11 is legal only when DATA_W=64.
REQ-010 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 req_addr  input  ADDR_W  byte address.
REQ-012 req_wdata  input  DATA_W  store data, right-justified.
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  consumer accepts the response.
REQ-015 resp_rdata  output  DATA_W  extended load data; 0 for stores.
REQ-016 resp_err  output  1  misaligned or illegal-size request.
REQ-017 mem_addr  output  ADDR_W  word-aligned address, low OFF_W bits forced to 0.
REQ-018 mem_rd_en  output  1  single-cycle read strobe.
REQ-019 mem_rdata  input  DATA_W  read word.
REQ-020 mem_rvalid  input  1  mem_rdata valid; arrives 1 or more cycles after mem_rd_en.
REQ-021 mem_wr_en  output  1  single-cycle write strobe.
REQ-022 mem_wdata  output  DATA_W  full merged word.

Function
REQ-023 The FSM SHALL have the states IDLE, RD, WAIT, WR and RESP; req_ready=1 only in IDLE.
REQ-024 In IDLE, when req_valid is high, the unit SHALL register every req_* field and leave IDLE on the next edge.
- Error request -> RESP.
- Full-width store -> WR.
- Any other request -> RD.
REQ-025 A request SHALL be an error when either condition holds; an error request SHALL produce no mem_rd_en and no mem_wr_en.
- Its low address bits are not a multiple of its size.
- req_size=11 while DATA_W=32.
REQ-026 RD SHALL assert mem_rd_en for exactly one cycle, then go to WAIT.
REQ-027 WAIT SHALL hold until mem_rvalid=1 and capture mem_rdata on that cycle.
- Load -> RESP.
- Store -> WR.
- mem_rvalid outside WAIT SHALL be ignored.
REQ-028 Load extraction SHALL select the byte lane(s) at the registered offset and extend them to DATA_W per req_unsigned.
REQ-029 The store merge SHALL replace only the addressed lane(s) of the captured word with the low bits of req_wdata and keep all other bits unchanged.
- Full-width store: mem_wdata = req_wdata.
REQ-030 WR SHALL assert mem_wr_en for exactly one cycle with mem_wdata stable, then go to RESP.
REQ-031 RESP SHALL hold resp_valid and the response fields stable until resp_ready=1, then return to IDLE.
- A new request is accepted no earlier than the following cycle.
REQ-032 mem_addr SHALL stay stable from RD through WR.
REQ-033 Latency for zero-wait memory with resp_ready held high:
- Load: resp_valid 3 cycles after acceptance.
- Sub-word store: resp_valid 4 cycles after acceptance.
- Full-width store: resp_valid 2 cycles after acceptance.
- Error: resp_valid 1 cycle after acceptance.
REQ-034 At most one request SHALL be outstanding; there is no request queue.

Reset
REQ-035 Asserting rst_n low SHALL immediately force the following, including mid-operation:
- state = IDLE.
- req_ready = 1 (after release).
- resp_valid, mem_rd_en, mem_wr_en and resp_err = 0.
- resp_rdata, mem_addr and mem_wdata = 0.
REQ-036 A read response that arrives after reset SHALL be discarded, because WAIT is not active.

Verification
REQ-037 DATA_W=32, word at 0x100 = 0xAABBCCDD; load byte, addr 0x103, signed -> resp_rdata=0xFFFFFFAA with resp_err=0.
REQ-038 Same word; store half 0x1234 at addr 0x102 -> exactly one mem_rd_en, then mem_wr_en with mem_wdata=0x1234CCDD.
REQ-039 Load half at addr 0x101 -> resp_err=1, resp_valid after 1 cycle, and no memory strobe.
REQ-040 DATA_W=64; store dword 0x0123456789ABCDEF at 0x08 -> no mem_rd_en, and mem_wr_en with that exact data.
REQ-041 mem_rvalid delayed 5 cycles and resp_ready held low 3 cycles -> req_ready stays 0 throughout and all outputs stay stable.
REQ-042 rst_n asserted low during WAIT, then mem_rvalid arrives -> no write occurs, the unit returns to IDLE, and the next request completes normally.

Source files
------------

// File: rtl/mem_rmw_unit.sv
// mem_rmw_unit: byte/half/word(/dword) load-store front end over a
// word-wide memory; sub-word stores are done as read-modify-write.
module mem_rmw_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam logic [1:0] SZ_FULL = (DATA_W == 64) ? 2'b11 : 2'b10;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
    state_t state, state_nx;

    logic              r_we, r_uns, r_err;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic [DATA_W-1:0] r_wdata, r_word;
    logic              req_err, req_full, accept;
    logic [OFF_W+2:0]  sh;
    logic [DATA_W-1:0] lane, lane_sh, wdata_sh, word_sh, ld_ext;
    logic              ld_sign;

    assign accept   = (state == IDLE) && req_valid;
    assign req_full = (req_size == SZ_FULL);

    always_comb begin
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = (DATA_W == 32) || (|req_addr[2:0]);
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (req_we && req_full)
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:   state_nx = WAIT;
            WAIT: if (mem_rvalid) state_nx = r_we ? WR : RESP;
            WR:   state_nx = RESP;
            RESP: if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            r_we     <= 1'b0;
            r_uns    <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= 2'b00;
            r_off    <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            mem_addr <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                r_we     <= req_we;
                r_uns    <= req_unsigned;
                r_err    <= req_err;
                r_size   <= req_size;
                r_off    <= req_addr[OFF_W-1:0];
                r_wdata  <= req_wdata;
                r_word   <= '0;
                mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
            if ((state == WAIT) && mem_rvalid)
                r_word <= mem_rdata;
        end
    end

    // lane is the right-justified mask of the access; shifted into place
    // it serves both load extraction and store merge.
    always_comb begin
        sh      = {r_off, 3'b000};
        word_sh = r_word >> sh;
        unique case (r_size)
            2'b00: begin
                lane    = DATA_W'(8'hFF);
                ld_sign = word_sh[7];
            end
            2'b01: begin
                lane    = DATA_W'(16'hFFFF);
                ld_sign = word_sh[15];
            end
            2'b10: begin
                lane    = DATA_W'(32'hFFFF_FFFF);
                ld_sign = word_sh[31];
            end
            default: begin
                lane    = '1;
                ld_sign = word_sh[DATA_W-1];
            end
        endcase
        lane_sh  = lane << sh;
        wdata_sh = (r_wdata & lane) << sh;
        ld_ext   = (word_sh & lane) | ((ld_sign && !r_uns) ? ~lane : '0);
    end

    assign req_ready  = (state == IDLE);
    assign mem_rd_en  = (state == RD);
    assign mem_wr_en  = (state == WR);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_we && !r_err) ? ld_ext : '0;
    assign mem_wdata  = (r_word & ~lane_sh) | wdata_sh;

endmodule

// File: tb/tb_mem_rmw_unit.sv
// tb_mem_rmw_unit: scoreboard bench for mem_rmw_unit (32-bit instance
// with a variable-latency memory model, plus a 64-bit instance).
module tb_mem_rmw_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_rd_en, mem_wr_en;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    mem_rmw_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
    );

    logic        d_req_valid = 1'b0, d_req_we = 1'b0, d_req_unsigned = 1'b0;
    logic [1:0]  d_req_size = 2'b00;
    logic [31:0] d_req_addr = '0, d_mem_addr;
    logic [63:0] d_req_wdata = '0, d_resp_rdata, d_mem_wdata;
    logic [63:0] d_mem_rdata = 64'h0123_4567_89AB_CDEF;
    logic        d_req_ready, d_resp_valid, d_resp_err, d_mem_rd_en, d_mem_wr_en;
    logic        d_resp_ready = 1'b1, d_mem_rvalid = 1'b0, d_pend = 1'b0;
    int          d_rd = 0;

    mem_rmw_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we),
        .req_size(d_req_size), .req_unsigned(d_req_unsigned),
        .req_addr(d_req_addr), .req_wdata(d_req_wdata),
        .resp_valid(d_resp_valid), .resp_ready(d_resp_ready),
        .resp_rdata(d_resp_rdata), .resp_err(d_resp_err),
        .mem_addr(d_mem_addr), .mem_rd_en(d_mem_rd_en), .mem_rdata(d_mem_rdata),
        .mem_rvalid(d_mem_rvalid), .mem_wr_en(d_mem_wr_en),
        .mem_wdata(d_mem_wdata)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sbq[$];
    exp_t me;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    int          rd_delay = 0, rd_cnt = 0, n_rd = 0, n_wr = 0;
    logic [31:0] rd_addr_q = '0, last_wdata = '0;
    int          cyc = 0, acc_cyc = 0, base_rd = 0, base_wr = 0;
    logic        in_flight = 1'b0;
    logic [31:0] exp_addr = '0;
    logic        prev_v = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
    logic [31:0] prev_rdata = '0;

    always @(posedge clk) cyc++;

    // memory: rvalid comes rd_delay cycles after the earliest legal slot
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem[rd_addr_q[9:2]];
            end
        end
        if (mem_rd_en) begin
            rd_cnt    = rd_delay + 1;
            rd_addr_q = mem_addr;
            n_rd++;
        end
        if (mem_wr_en) begin
            mem[mem_addr[9:2]] = mem_wdata;
            last_wdata = mem_wdata;
            n_wr++;
        end
    end

    always @(negedge clk) begin
        d_mem_rvalid = d_pend;
        d_pend = d_mem_rd_en;
        if (d_mem_rd_en) d_rd++;
    end

    always @(negedge clk) begin
        if (in_flight) begin
            chk("busy_ready", req_ready, 1'b0);
            chk("addr_hold", mem_addr, exp_addr);
        end
        if (resp_valid && prev_v && !prev_hs) begin
            chk("hold_rdata", resp_rdata, prev_rdata);
            chk("hold_err", resp_err, prev_err);
        end
        if (resp_valid && !prev_v && sbq.size() > 0 && sbq[0].lat >= 0)
            chk("latency", cyc - acc_cyc, sbq[0].lat);
        if (resp_valid && resp_ready) begin
            if (sbq.size() == 0) begin
                chk("stray_resp", resp_valid, 1'b0);
            end else begin
                me = sbq.pop_front();
                chk("rdata", resp_rdata, me.rdata);
                chk("err", resp_err, me.err);
                chk("rd_strobes", n_rd - base_rd, me.rd);
                chk("wr_strobes", n_wr - base_wr, me.wr);
                if (me.wr != 0) chk("wdata", last_wdata, me.wdata);
                in_flight = 1'b0;
            end
        end
        prev_v     = resp_valid;
        prev_hs    = resp_valid && resp_ready;
        prev_rdata = resp_rdata;
        prev_err   = resp_err;
    end

    function automatic logic [31:0] ld_model(input logic [31:0] w,
        input logic [1:0] sz, input logic [1:0] off, input logic uns);
        int nb;
        logic [31:0] r;
        nb = 1 << sz;
        r  = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = w[8*(off+i) +: 8];
        if (!uns && r[8*nb-1])
            for (int i = nb; i < 4; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] w,
        input logic [1:0] sz, input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < (1 << sz); i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic issue(input logic we, input logic [1:0] sz,
        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_flight = 1'b1;
        acc_cyc   = cyc - 1;
        base_rd   = n_rd;
        base_wr   = n_wr;
        exp_addr  = {addr[31:2], 2'b00};
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz,
        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
        input int dly, input int stall);
        exp_t e;
        int   nb, n;
        logic [31:0] w;
        nb = 1 << sz;
        w  = ref_mem[addr[9:2]];
        e.err = (sz == 2'b11) || ((int'(addr[1:0]) % nb) != 0);
        e.rdata = '0; e.rd = 0; e.wr = 0; e.wdata = '0;
        if (!e.err) begin
            if (!we) begin
                e.rd = 1;
                e.rdata = ld_model(w, sz, addr[1:0], uns);
            end else begin
                e.wr = 1;
                e.rd = (sz == 2'b10) ? 0 : 1;
                e.wdata = st_model(w, sz, addr[1:0], wd);
                ref_mem[addr[9:2]] = e.wdata;
            end
        end
        if (dly != 0) e.lat = -1;
        else if (e.err) e.lat = 1;
        else if (!we) e.lat = 3;
        else if (sz == 2'b10) e.lat = 2;
        else e.lat = 4;
        rd_delay = dly;
        sbq.push_back(e);
        issue(we, sz, uns, addr, wd);
        if (stall > 0) begin
            resp_ready = 1'b0;
            n = 0;
            while (!resp_valid && n < 50) begin @(negedge clk); n++; end
            repeat (stall) @(negedge clk);
            resp_ready = 1'b1;
        end
        n = 0;
        while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (sbq.size() != 0) begin
            chk("resp_timeout", sbq.size(), 0);
            sbq.delete();
            in_flight = 1'b0;
        end
    endtask

    initial begin
        int n, wr0;
        logic [1:0] sz;
        logic [1:0] off;
        for (int i = 0; i < 256; i++) mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        mem[8'h40] = 32'hAABB_CCDD;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        #1 rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);

        do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0);
        do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 0);
        do_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0);
        do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFF_1234, 0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0);
        do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_005A, 0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 0, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, 0, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h106, 32'h1111_2222, 0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 5, 3);
        do_req(1'b1, 2'b00, 1'b0, 32'h107, 32'h0000_0042, 5, 3);

        for (int k = 0; k < 24; k++) begin
            sz  = 2'($urandom_range(0, 3));
            off = 2'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'(off),
                   $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // reset while waiting for read data of a sub-word store
        rd_delay = 4;
        issue(1'b1, 2'b00, 1'b0, 32'h108, 32'h0000_00EE);
        wr0 = n_wr;
        n = 0;
        while (n_rd == base_rd && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        in_flight = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", resp_valid, 1'b0);
        chk("mid_rst_wr_en", mem_wr_en, 1'b0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        chk("mid_rst_wdata", mem_wdata, 32'h0);
        chk("mid_rst_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_write_after_rst", n_wr - wr0, 0);
        chk("idle_after_rst", req_ready, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 0, 0);
        do_req(1'b1, 2'b00, 1'b0, 32'h109, 32'h0000_0077, 0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 0, 0);

        // 64-bit instance: full-width store and a sign-extended byte load
        d_req_we = 1'b1; d_req_size = 2'b11; d_req_addr = 32'h8;
        d_req_wdata = 64'h0123_4567_89AB_CDEF; d_req_valid = 1'b1;
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        n = 0;
        while (!d_mem_wr_en && n < 10) begin @(negedge clk); n++; end
        chk("d64_wr_en", d_mem_wr_en, 1'b1);
        chk("d64_wdata", d_mem_wdata, 64'h0123_4567_89AB_CDEF);
        chk("d64_addr", d_mem_addr, 32'h8);
        n = 0;
        while (!d_resp_valid && n < 10) begin @(negedge clk); n++; end
        chk("d64_st_err", d_resp_err, 1'b0);
        chk("d64_no_rd", d_rd, 0);
        @(negedge clk);
        d_req_we = 1'b0; d_req_size = 2'b00; d_req_addr = 32'h0B;
        d_req_unsigned = 1'b0; d_req_valid = 1'b1;
        n = 0;
        while (!d_req_ready && n < 10) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        n = 0;
        while (!d_resp_valid && n < 20) begin @(negedge clk); n++; end
        chk("d64_ld_rdata", d_resp_rdata, 64'hFFFF_FFFF_FFFF_FF89);
        chk("d64_ld_err", d_resp_err, 1'b0);
        chk("d64_ld_addr", d_mem_addr, 32'h8);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
